// File: rtl/axi_lite_mem_slave_ws.sv
// ---------------------------------------------------------------------------
// axi_lite_mem_slave_ws
//
// AXI-Lite memory slave with programmable wait states and address decode.
// The AW and W channels are accepted independently, in either order or in the
// same cycle. Read and write paths run concurrently. Accesses outside
// [BASE_ADDR, BASE_ADDR+MEM_SIZE) return SLVERR, leave memory untouched and
// read back as zero. Memory contents are not reset.
//
// Handshake rule (all five channels): a transfer happens on the rising edge
// where valid and ready are both high. A source that has raised valid keeps
// valid and its payload stable until that edge. b_* and r_* are registered
// and held stable until their handshake.
//
// Optional feature: define AXI_LITE_MEM_BACKPRESSURE_EN to gate aw_ready,
// w_ready and ar_ready with bits 0..2 of a free-running 8-bit Galois LFSR.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   aw_addr/valid/ready   write address channel
//   w_data/strb/valid/ready write data channel
//   b_valid/resp/ready    write response channel
//   ar_addr/valid/ready   read address channel
//   r_valid/data/resp/ready read data channel
//   wr_state_dbg          current write FSM state (W_IDLE/W_WAIT/W_RESP)
//   rd_state_dbg          current read FSM state  (R_IDLE/R_WAIT/R_RESP)
// ---------------------------------------------------------------------------
module axi_lite_mem_slave_ws #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    MEM_SIZE   = 4096,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    WR_LATENCY = 0,
  parameter int                    RD_LATENCY = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   aw_addr,
  input  logic                    aw_valid,
  output logic                    aw_ready,
  input  logic [DATA_WIDTH-1:0]   w_data,
  input  logic [DATA_WIDTH/8-1:0] w_strb,
  input  logic                    w_valid,
  output logic                    w_ready,
  output logic                    b_valid,
  output logic [1:0]              b_resp,
  input  logic                    b_ready,
  input  logic [ADDR_WIDTH-1:0]   ar_addr,
  input  logic                    ar_valid,
  output logic                    ar_ready,
  output logic                    r_valid,
  output logic [DATA_WIDTH-1:0]   r_data,
  output logic [1:0]              r_resp,
  input  logic                    r_ready,
  output logic [1:0]              wr_state_dbg,
  output logic [1:0]              rd_state_dbg
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int DEPTH  = MEM_SIZE / STRB_W;
  localparam int IDX_W  = $clog2(DEPTH);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // -------------------------------------------------------------------------
  // Ready gating (LFSR backpressure or always-on)
  // -------------------------------------------------------------------------
  logic [2:0] bp;

`ifdef AXI_LITE_MEM_BACKPRESSURE_EN
  logic [7:0] lfsr;

  // Right-shifting Galois form; mask 8'hB8 realises taps 8,6,5,4.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr <= 8'hA5;
    else        lfsr <= {1'b0, lfsr[7:1]} ^ (lfsr[0] ? 8'hB8 : 8'h00);
  end

  assign bp = lfsr[2:0];
`else
  assign bp = 3'b111;
`endif

  // -------------------------------------------------------------------------
  // Write path
  // -------------------------------------------------------------------------
  w_state_t              w_state, w_state_n;
  logic [3:0]            wcnt, wcnt_n;
  logic                  aw_done, w_done;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_W-1:0]     w_strb_q;
  logic                  aw_hs, w_hs, w_commit;
  logic [ADDR_WIDTH-1:0] w_off;
  logic                  w_in_range;
  logic [IDX_W-1:0]      w_idx;

  // Readies are forced low while reset is asserted, not just by FSM state.
  assign aw_ready = rst_n && (w_state == W_IDLE) && !aw_done && bp[0];
  assign w_ready  = rst_n && (w_state == W_IDLE) && !w_done  && bp[1];
  assign aw_hs    = aw_valid && aw_ready;
  assign w_hs     = w_valid && w_ready;

  // Offset wraps to a huge value for addresses below BASE_ADDR, so a single
  // unsigned compare covers both ends of the window. BASE_ADDR is aligned to
  // MEM_SIZE, so the word index is just a slice of the offset.
  assign w_off      = aw_addr_q - BASE_ADDR;
  assign w_in_range = (w_off < ADDR_WIDTH'(MEM_SIZE));
  assign w_idx      = w_off[OFF_W +: IDX_W];

  always_comb begin
    w_state_n = w_state;
    wcnt_n    = wcnt;
    w_commit  = 1'b0;
    case (w_state)
      W_IDLE: begin
        if ((aw_done || aw_hs) && (w_done || w_hs)) begin
          w_state_n = W_WAIT;
          wcnt_n    = 4'(WR_LATENCY);
        end
      end
      W_WAIT: begin
        if (wcnt == 4'd0) begin
          w_commit  = 1'b1;
          w_state_n = W_RESP;
        end else begin
          wcnt_n = wcnt - 4'd1;
        end
      end
      W_RESP: begin
        if (b_ready) w_state_n = W_IDLE;
      end
      default: w_state_n = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state   <= W_IDLE;
      wcnt      <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      b_valid   <= 1'b0;
      b_resp    <= RESP_OKAY;
    end else begin
      w_state <= w_state_n;
      wcnt    <= wcnt_n;
      if (aw_hs) begin
        aw_done   <= 1'b1;
        aw_addr_q <= aw_addr;
      end
      if (w_hs) begin
        w_done   <= 1'b1;
        w_data_q <= w_data;
        w_strb_q <= w_strb;
      end
      if (w_commit) begin
        b_valid <= 1'b1;
        b_resp  <= w_in_range ? RESP_OKAY : RESP_SLVERR;
      end
      if ((w_state == W_RESP) && b_ready) begin
        b_valid <= 1'b0;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
    end
  end

  // Storage has no reset. w_commit only occurs in W_WAIT, which reset
  // leaves asynchronously, so an aborted write never lands.
  always_ff @(posedge clk) begin
    if (w_commit && w_in_range) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (w_strb_q[i]) mem[w_idx][8*i +: 8] <= w_data_q[8*i +: 8];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Read path
  // -------------------------------------------------------------------------
  r_state_t              r_state, r_state_n;
  logic [3:0]            rcnt, rcnt_n;
  logic [ADDR_WIDTH-1:0] ar_addr_q;
  logic                  ar_hs, r_sample;
  logic [ADDR_WIDTH-1:0] r_off;
  logic                  r_in_range;
  logic [IDX_W-1:0]      r_idx;

  assign ar_ready   = rst_n && (r_state == R_IDLE) && bp[2];
  assign ar_hs      = ar_valid && ar_ready;
  assign r_off      = ar_addr_q - BASE_ADDR;
  assign r_in_range = (r_off < ADDR_WIDTH'(MEM_SIZE));
  assign r_idx      = r_off[OFF_W +: IDX_W];

  always_comb begin
    r_state_n = r_state;
    rcnt_n    = rcnt;
    r_sample  = 1'b0;
    case (r_state)
      R_IDLE: begin
        if (ar_hs) begin
          r_state_n = R_WAIT;
          rcnt_n    = 4'(RD_LATENCY);
        end
      end
      R_WAIT: begin
        if (rcnt == 4'd0) begin
          r_sample  = 1'b1;
          r_state_n = R_RESP;
        end else begin
          rcnt_n = rcnt - 4'd1;
        end
      end
      R_RESP: begin
        if (r_ready) r_state_n = R_IDLE;
      end
      default: r_state_n = R_IDLE;
    endcase
  end

  // mem is sampled with the pre-edge value, so a write committing on the
  // same edge to the same word is not visible to this read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= R_IDLE;
      rcnt      <= '0;
      ar_addr_q <= '0;
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_resp    <= RESP_OKAY;
    end else begin
      r_state <= r_state_n;
      rcnt    <= rcnt_n;
      if (ar_hs) ar_addr_q <= ar_addr;
      if (r_sample) begin
        r_valid <= 1'b1;
        r_data  <= r_in_range ? mem[r_idx] : '0;
        r_resp  <= r_in_range ? RESP_OKAY : RESP_SLVERR;
      end
      if ((r_state == R_RESP) && r_ready) r_valid <= 1'b0;
    end
  end

  assign wr_state_dbg = w_state;
  assign rd_state_dbg = r_state;

endmodule

// File: tb/tb_axi_lite_mem_slave_ws.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_mem_slave_ws
//
// Bench for axi_lite_mem_slave_ws with WR_LATENCY=3, RD_LATENCY=5 and a
// 128-byte window at 0x1000. A byte-level reference memory predicts data and
// responses; latencies come from the 1+LATENCY rule.
// Inputs change 1 time unit after a rising edge; outputs are sampled on the
// falling edge. cyc counts rising edges, so at a falling edge "cyc+1" is the
// edge a handshake seen there will occur on.
// ---------------------------------------------------------------------------
module tb_axi_lite_mem_slave_ws;

  localparam int          AW       = 32;
  localparam int          DW       = 32;
  localparam int          MEM_SIZE = 128;
  localparam int          WORDS    = MEM_SIZE / 4;
  localparam int          WR_LAT   = 3;
  localparam int          RD_LAT   = 5;
  localparam int          TIMEOUT  = 200;
  localparam logic [31:0] BASE     = 32'h0000_1000;

  logic          clk, rst_n;
  logic [AW-1:0] aw_addr, ar_addr;
  logic          aw_valid, aw_ready, w_valid, w_ready, ar_valid, ar_ready;
  logic [DW-1:0] w_data, r_data;
  logic [3:0]    w_strb;
  logic          b_valid, b_ready, r_valid, r_ready;
  logic [1:0]    b_resp, r_resp, wr_state_dbg, rd_state_dbg;

  logic [DW-1:0] ref_mem [WORDS];
  logic [DW-1:0] exp_q[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc    = 0;

  axi_lite_mem_slave_ws #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_SIZE(MEM_SIZE),
    .BASE_ADDR(BASE), .WR_LATENCY(WR_LAT), .RD_LATENCY(RD_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .aw_addr(aw_addr), .aw_valid(aw_valid), .aw_ready(aw_ready),
    .w_data(w_data), .w_strb(w_strb), .w_valid(w_valid), .w_ready(w_ready),
    .b_valid(b_valid), .b_resp(b_resp), .b_ready(b_ready),
    .ar_addr(ar_addr), .ar_valid(ar_valid), .ar_ready(ar_ready),
    .r_valid(r_valid), .r_data(r_data), .r_resp(r_resp), .r_ready(r_ready),
    .wr_state_dbg(wr_state_dbg), .rd_state_dbg(rd_state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1ms;
    $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic bit ref_in_range(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + MEM_SIZE);
  endfunction

  task automatic ref_write(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [1:0] resp);
    int idx;
    resp = 2'b10;
    if (ref_in_range(a)) begin
      idx = int'((a - BASE) / 4);
      for (int i = 0; i < 4; i++)
        if (s[i]) ref_mem[idx][8*i +: 8] = d[8*i +: 8];
      resp = 2'b00;
    end
  endtask

  task automatic ref_read(input logic [31:0] a, output logic [31:0] d,
                          output logic [1:0] resp);
    d    = 32'h0;
    resp = 2'b10;
    if (ref_in_range(a)) begin
      d    = ref_mem[int'((a - BASE) / 4)];
      resp = 2'b00;
    end
  endtask

  // ---------------- driver tasks ----------------
  // Start and end one time unit after a rising edge.
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input int aw_dly, input int w_dly,
                           input int b_stall, output logic [1:0] resp, output int lat);
    int aw_e, w_e, b_e;
    aw_e = -1; w_e = -1; b_e = -1; lat = -1; resp = 2'bxx;
    fork
      begin
        repeat (aw_dly) begin @(posedge clk); #1; end
        aw_addr = a; aw_valid = 1'b1;
        for (int k = 0; k < TIMEOUT && aw_e < 0; k++) begin
          @(negedge clk);
          if (aw_ready) aw_e = cyc + 1;
          @(posedge clk); #1;
        end
        aw_valid = 1'b0;
      end
      begin
        repeat (w_dly) begin @(posedge clk); #1; end
        w_data = d; w_strb = s; w_valid = 1'b1;
        for (int k = 0; k < TIMEOUT && w_e < 0; k++) begin
          @(negedge clk);
          if (w_ready) w_e = cyc + 1;
          @(posedge clk); #1;
        end
        w_valid = 1'b0;
      end
    join
    if (aw_e < 0 || w_e < 0) begin
      checks++; errors++;
      $display("FAIL wr_addr_data_timeout addr=%h aw_edge=%0d w_edge=%0d", a, aw_e, w_e);
      return;
    end
    for (int k = 0; k < TIMEOUT && b_e < 0; k++) begin
      @(negedge clk);
      if (b_valid) b_e = cyc;
    end
    if (b_e < 0) begin
      checks++; errors++;
      $display("FAIL wr_b_timeout addr=%h b_valid never rose", a);
      @(posedge clk); #1;
      return;
    end
    lat  = b_e - ((aw_e > w_e) ? aw_e : w_e);
    resp = b_resp;
    for (int k = 0; k < b_stall; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (b_valid !== 1'b1 || b_resp !== resp) begin
        errors++;
        $display("FAIL wr_b_stable got valid=%b resp=%b exp valid=1 resp=%b", b_valid, b_resp, resp);
      end
    end
    @(posedge clk); #1;
    b_ready = 1'b1;
    @(posedge clk); #1;
    b_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (b_valid !== 1'b0) begin
      errors++;
      $display("FAIL wr_b_clear got b_valid=%b exp 0", b_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic axi_read(input logic [31:0] a, input int ar_dly, input int r_stall,
                          output logic [31:0] d, output logic [1:0] resp, output int lat);
    int ar_e, r_e;
    ar_e = -1; r_e = -1; lat = -1; resp = 2'bxx; d = 'x;
    repeat (ar_dly) begin @(posedge clk); #1; end
    ar_addr = a; ar_valid = 1'b1;
    for (int k = 0; k < TIMEOUT && ar_e < 0; k++) begin
      @(negedge clk);
      if (ar_ready) ar_e = cyc + 1;
      @(posedge clk); #1;
    end
    ar_valid = 1'b0;
    if (ar_e < 0) begin
      checks++; errors++;
      $display("FAIL rd_ar_timeout addr=%h", a);
      return;
    end
    for (int k = 0; k < TIMEOUT && r_e < 0; k++) begin
      @(negedge clk);
      if (r_valid) r_e = cyc;
    end
    if (r_e < 0) begin
      checks++; errors++;
      $display("FAIL rd_r_timeout addr=%h r_valid never rose", a);
      @(posedge clk); #1;
      return;
    end
    lat = r_e - ar_e; d = r_data; resp = r_resp;
    for (int k = 0; k < r_stall; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (r_valid !== 1'b1 || r_data !== d || r_resp !== resp) begin
        errors++;
        $display("FAIL rd_r_stable got valid=%b data=%h resp=%b exp valid=1 data=%h resp=%b",
                 r_valid, r_data, r_resp, d, resp);
      end
    end
    @(posedge clk); #1;
    r_ready = 1'b1;
    @(posedge clk); #1;
    r_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (r_valid !== 1'b0) begin
      errors++;
      $display("FAIL rd_r_clear got r_valid=%b exp 0", r_valid);
    end
    @(posedge clk); #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; aw_valid = 0; w_valid = 0; ar_valid = 0; b_ready = 0; r_ready = 0;
    aw_addr = '0; ar_addr = '0; w_data = '0; w_strb = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({aw_ready, w_ready, ar_ready} !== 3'b000) begin
      errors++; $display("FAIL reset_readies got %b exp 000", {aw_ready, w_ready, ar_ready});
    end
    checks++;
    if ({b_valid, r_valid, b_resp, r_resp} !== 6'b0) begin
      errors++; $display("FAIL reset_resp got bv=%b rv=%b br=%b rr=%b exp all 0", b_valid, r_valid, b_resp, r_resp);
    end
    checks++;
    if (r_data !== 32'h0) begin
      errors++; $display("FAIL reset_r_data got %h exp 0", r_data);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({aw_ready, w_ready, ar_ready} !== 3'b111) begin
      errors++; $display("FAIL release_readies got %b exp 111", {aw_ready, w_ready, ar_ready});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_fill();
    logic [1:0] resp, eresp; int lat; logic [31:0] d;
    for (int i = 0; i < WORDS; i++) begin
      d = $urandom;
      axi_write(BASE + 32'(4*i), d, 4'hF, 0, 0, 0, resp, lat);
      ref_write(BASE + 32'(4*i), d, 4'hF, eresp);
      checks++;
      if (resp !== eresp || lat !== 1 + WR_LAT) begin
        errors++; $display("FAIL fill_write[%0d] got resp=%b lat=%0d exp resp=%b lat=%0d", i, resp, lat, eresp, 1 + WR_LAT);
      end
    end
  endtask

  task automatic test_same_cycle();
    logic [1:0] resp, eresp; int lat; logic [31:0] d, ed;
    axi_write(BASE + 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, resp, lat);
    ref_write(BASE + 32'h10, 32'hDEADBEEF, 4'hF, eresp);
    checks++;
    if (resp !== eresp || lat !== 1 + WR_LAT) begin
      errors++; $display("FAIL same_cycle_write got resp=%b lat=%0d exp resp=%b lat=%0d", resp, lat, eresp, 1 + WR_LAT);
    end
    ref_read(BASE + 32'h10, ed, eresp);
    exp_q.push_back(ed);
    axi_read(BASE + 32'h10, 0, 0, d, resp, lat);
    ed = exp_q.pop_front();
    checks++;
    if (d !== ed || resp !== eresp || lat !== 1 + RD_LAT) begin
      errors++; $display("FAIL same_cycle_read got d=%h resp=%b lat=%0d exp d=%h resp=%b lat=%0d", d, resp, lat, ed, eresp, 1 + RD_LAT);
    end
  endtask

  task automatic test_w_first();
    logic [1:0] resp, eresp; int lat, aw_e, b_e; logic [31:0] d, ed; bit bad;
    w_data = 32'h11223344; w_strb = 4'hF; w_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (w_ready !== 1'b1) begin errors++; $display("FAIL w_first_w_ready got %b exp 1", w_ready); end
    @(posedge clk); #1;
    w_valid = 1'b0;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (w_ready !== 1'b0 || b_valid !== 1'b0) bad = 1;
      @(posedge clk); #1;
    end
    aw_addr = BASE + 32'h20; aw_valid = 1'b1;
    @(negedge clk);
    if (aw_ready !== 1'b1) bad = 1;
    @(posedge clk); #1;
    aw_valid = 1'b0; aw_e = cyc; b_e = -1;
    for (int k = 0; k < TIMEOUT && b_e < 0; k++) begin
      @(negedge clk);
      if (b_valid) b_e = cyc;
      else if (w_ready !== 1'b0) bad = 1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL w_first_ready_hold got w_ready/b_valid high early exp low until B"); end
    ref_write(BASE + 32'h20, 32'h11223344, 4'hF, eresp);
    checks++;
    if (b_e - aw_e !== 1 + WR_LAT || b_resp !== eresp) begin
      errors++; $display("FAIL w_first_b got lat=%0d resp=%b exp lat=%0d resp=%b", b_e - aw_e, b_resp, 1 + WR_LAT, eresp);
    end
    @(posedge clk); #1; b_ready = 1'b1;
    @(posedge clk); #1; b_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (w_ready !== 1'b1 || b_valid !== 1'b0) begin
      errors++; $display("FAIL w_first_after_b got w_ready=%b b_valid=%b exp 1 0", w_ready, b_valid);
    end
    @(posedge clk); #1;
    ref_read(BASE + 32'h20, ed, eresp);
    axi_read(BASE + 32'h20, 0, 0, d, resp, lat);
    checks++;
    if (d !== ed || resp !== eresp) begin
      errors++; $display("FAIL w_first_read got d=%h resp=%b exp d=%h resp=%b", d, resp, ed, eresp);
    end
  endtask

  task automatic test_strobe();
    logic [1:0] resp, eresp; int lat; logic [31:0] d, ed;
    logic [3:0] strbs [3];
    logic [31:0] datas [3];
    strbs = '{4'hF, 4'b0101, 4'h0};
    datas = '{32'hFFFFFFFF, 32'h00000000, 32'h12345678};
    for (int i = 0; i < 3; i++) begin
      axi_write(BASE + 32'h30, datas[i], strbs[i], i, 0, 0, resp, lat);
      ref_write(BASE + 32'h30, datas[i], strbs[i], eresp);
      ref_read(BASE + 32'h30, ed, eresp);
      checks++;
      if (resp !== 2'b00) begin errors++; $display("FAIL strobe_write[%0d] got resp=%b exp 00", i, resp); end
      axi_read(BASE + 32'h30, 0, 0, d, resp, lat);
      checks++;
      if (d !== ed || resp !== eresp) begin
        errors++; $display("FAIL strobe_read[%0d] got d=%h resp=%b exp d=%h resp=%b", i, d, resp, ed, eresp);
      end
    end
  endtask

  task automatic test_decode();
    logic [1:0] resp, eresp; int lat; logic [31:0] d, ed;
    logic [31:0] addrs [4];
    addrs = '{BASE + MEM_SIZE, BASE - 32'd4, BASE + MEM_SIZE - 32'd4, BASE + MEM_SIZE + 32'h100};
    for (int i = 0; i < 4; i++) begin
      axi_write(addrs[i], 32'h55AA55AA ^ 32'(i), 4'hF, 0, 1, 0, resp, lat);
      ref_write(addrs[i], 32'h55AA55AA ^ 32'(i), 4'hF, eresp);
      checks++;
      if (resp !== eresp) begin errors++; $display("FAIL decode_write %h got resp=%b exp %b", addrs[i], resp, eresp); end
      ref_read(addrs[i], ed, eresp);
      axi_read(addrs[i], 0, 0, d, resp, lat);
      checks++;
      if (d !== ed || resp !== eresp) begin
        errors++; $display("FAIL decode_read %h got d=%h resp=%b exp d=%h resp=%b", addrs[i], d, resp, ed, eresp);
      end
    end
    // Word 0 is where an out-of-range write would alias if decode were wrong.
    ref_read(BASE, ed, eresp);
    axi_read(BASE, 0, 0, d, resp, lat);
    checks++;
    if (d !== ed || resp !== eresp) begin
      errors++; $display("FAIL decode_alias got d=%h resp=%b exp d=%h resp=%b", d, resp, ed, eresp);
    end
  endtask

  task automatic test_stall();
    logic [1:0] resp, eresp; int lat; logic [31:0] d, ed;
    axi_write(BASE + 32'h40, 32'hCAFEF00D, 4'hF, 1, 0, 4, resp, lat);
    ref_write(BASE + 32'h40, 32'hCAFEF00D, 4'hF, eresp);
    checks++;
    if (resp !== eresp || lat !== 1 + WR_LAT) begin
      errors++; $display("FAIL stall_write got resp=%b lat=%0d exp resp=%b lat=%0d", resp, lat, eresp, 1 + WR_LAT);
    end
    ref_read(BASE + 32'h40, ed, eresp);
    axi_read(BASE + 32'h40, 0, 4, d, resp, lat);
    checks++;
    if (d !== ed || resp !== eresp || lat !== 1 + RD_LAT) begin
      errors++; $display("FAIL stall_read got d=%h resp=%b lat=%0d exp d=%h resp=%b lat=%0d", d, resp, lat, ed, eresp, 1 + RD_LAT);
    end
  endtask

  // Read AR two edges before the write completes AW/W: with latencies 5 and
  // 3 the read sample and write commit land on the same edge.
  task automatic test_collision();
    logic [1:0] wresp, rresp, eresp; int wlat, rlat; logic [31:0] d, ed_old, ed_new;
    ref_read(BASE + 32'h44, ed_old, eresp);
    fork
      axi_write(BASE + 32'h44, ~ed_old, 4'hF, 2, 2, 0, wresp, wlat);
      axi_read(BASE + 32'h44, 0, 0, d, rresp, rlat);
    join
    ref_write(BASE + 32'h44, ~ed_old, 4'hF, eresp);
    checks++;
    if (d !== ed_old || rresp !== 2'b00 || wresp !== 2'b00) begin
      errors++; $display("FAIL collision_old got d=%h rresp=%b wresp=%b exp d=%h resp=00", d, rresp, wresp, ed_old);
    end
    ref_read(BASE + 32'h44, ed_new, eresp);
    axi_read(BASE + 32'h44, 0, 0, d, rresp, rlat);
    checks++;
    if (d !== ed_new) begin
      errors++; $display("FAIL collision_new got d=%h exp d=%h", d, ed_new);
    end
  endtask

  task automatic test_random();
    logic [1:0] resp, eresp; int lat; logic [31:0] a, d, ed; logic [3:0] s;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 9))
        0:       a = BASE + MEM_SIZE + 32'(4 * $urandom_range(0, 63));
        1:       a = BASE - 32'(4 * $urandom_range(1, 64));
        default: a = BASE + 32'(4 * $urandom_range(0, WORDS - 1)) + 32'($urandom_range(0, 3));
      endcase
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom; s = 4'($urandom_range(0, 15));
        axi_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), resp, lat);
        ref_write(a, d, s, eresp);
        checks++;
        if (resp !== eresp || lat !== 1 + WR_LAT) begin
          errors++; $display("FAIL random_write[%0d] %h got resp=%b lat=%0d exp resp=%b lat=%0d", n, a, resp, lat, eresp, 1 + WR_LAT);
        end
      end else begin
        ref_read(a, ed, eresp);
        exp_q.push_back(ed);
        axi_read(a, $urandom_range(0, 3), $urandom_range(0, 2), d, resp, lat);
        ed = exp_q.pop_front();
        checks++;
        if (d !== ed || resp !== eresp || lat !== 1 + RD_LAT) begin
          errors++; $display("FAIL random_read[%0d] %h got d=%h resp=%b lat=%0d exp d=%h resp=%b lat=%0d", n, a, d, resp, lat, ed, eresp, 1 + RD_LAT);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] resp, eresp; int lat; logic [31:0] d, ed; bit bad;
    ref_read(BASE + 32'h50, ed, eresp);
    aw_addr = BASE + 32'h50; w_data = ~ed; w_strb = 4'hF;
    aw_valid = 1'b1; w_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (aw_ready !== 1'b1 || w_ready !== 1'b1) begin
      errors++; $display("FAIL reset_mid_accept got aw_ready=%b w_ready=%b exp 1 1", aw_ready, w_ready);
    end
    @(posedge clk); #1;
    aw_valid = 1'b0; w_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (b_valid !== 1'b0 || aw_ready !== 1'b0) begin
      errors++; $display("FAIL reset_mid_async got b_valid=%b aw_ready=%b exp 0 0", b_valid, aw_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (b_valid !== 1'b0) bad = 1;
      @(posedge clk); #1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL reset_mid_no_b got b_valid=1 exp 0 after aborted write"); end
    axi_read(BASE + 32'h50, 0, 0, d, resp, lat);
    checks++;
    if (d !== ed || resp !== eresp) begin
      errors++; $display("FAIL reset_mid_mem got d=%h resp=%b exp d=%h resp=%b", d, resp, ed, eresp);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_same_cycle();
    test_w_first();
    test_strobe();
    test_decode();
    test_stall();
    test_collision();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
